jtkcpu_cen: RTL

Clock-enable and wait-state generator feeding the cen/cen2 inputs of the Konami CPU core.
- Fractional divider derives two interleaved enables from the system clock: cen2 (quadrature phase) and cen (main phase).
- Stretches the main phase while a bus access is pending and the memory side has not acknowledged it through dtack.
- Sits between the system clock domain and jtkcpu, next to the address decoder that drives cs/dtack.

---
 rtl/jtkcpu_cen.sv | 76 +++++++
 1 files changed

// File: rtl/jtkcpu_cen.sv
// jtkcpu_cen: fractional cen/cen2 generator with dtack wait-state stretching.
// Define JTKCPU_CEN_TIMEOUT_EN to abort stalls after TIMEOUT clks with a bus_err pulse.
module jtkcpu_cen #(
    parameter int NUM     = 1,
    parameter int DEN     = 4,
    parameter int CNTW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       dtack,
    output logic       cen,
    output logic       cen2,
    output logic       stall,
    output logic [7:0] wait_cycles,
    output logic       bus_err
);
    if (2*NUM > DEN || 2*NUM > (1 << CNTW) - 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("jtkcpu_cen: illegal NUM/DEN/CNTW/TIMEOUT combination");
    end
    logic [CNTW-1:0] acc, nx;
    logic            ph, tick, hold, tout, leave;
    logic [7:0]      cnt;
    assign nx    = acc + CNTW'(2*NUM);
    assign tick  = nx >= CNTW'(DEN);
    assign hold  = cs && !dtack;
`ifdef JTKCPU_CEN_TIMEOUT_EN
    assign tout  = cnt >= 8'(TIMEOUT);
`else
    assign tout  = 1'b0;
`endif
    assign leave = !hold || tout;
    // The accumulator stays frozen for the whole stall, including the exit clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            ph          <= 1'b0;
            cen         <= 1'b0;
            cen2        <= 1'b0;
            stall       <= 1'b0;
            wait_cycles <= 8'd0;
            bus_err     <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            cen     <= 1'b0;
            cen2    <= 1'b0;
            bus_err <= 1'b0;
            if (stall) begin
                if (leave) begin
                    cen         <= 1'b1;
                    stall       <= 1'b0;
                    ph          <= 1'b0;
                    wait_cycles <= cnt;
                    bus_err     <= hold;
                end else begin
                    cnt <= cnt == 8'hff ? cnt : cnt + 8'd1;
                end
            end else begin
                acc <= tick ? nx - CNTW'(DEN) : nx;
                if (tick) begin
                    if (!ph) begin
                        cen2 <= 1'b1;
                        ph   <= 1'b1;
                    end else if (!hold) begin
                        cen <= 1'b1;
                        ph  <= 1'b0;
                    end else begin
                        stall <= 1'b1;
                        cnt   <= 8'd1;
                    end
                end
            end
        end
    end
endmodule
